// File: rtl/lut_init_pkg.sv
// Shared types and defaults for the SFU activation-table loader.
package lut_init_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        RDBACK = 2'd2,
        FINISH = 2'd3
    } lut_init_state_e;

    localparam int unsigned LUT_DEPTH_DEFAULT = 4096;
    localparam int unsigned SFU_LUT_W         = 16;

endpackage

// File: rtl/lut_chk_lane.sv
// Per-lane XOR accumulator over readback data, compared against the write checksum.
module lut_chk_lane
    import lut_init_pkg::*;
#(
    parameter int unsigned DATA_W = SFU_LUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] exp_chk,
    output logic              mismatch
);

    logic [DATA_W-1:0] rchk_q, rchk_d;

    always_comb begin
        rchk_d = rchk_q;
        if (clr) begin
            rchk_d = '0;
        end else if (en) begin
            rchk_d = rchk_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rchk_q <= '0;
        end else begin
            rchk_q <= rchk_d;
        end
    end

    assign mismatch = (rchk_q != exp_chk);

endmodule

// File: rtl/lut_init_sequencer.sv
// Streams words into one or more LUT banks, optionally reads them back for a
// checksum compare, then pulses done/cfg_kick.
module lut_init_sequencer
    import lut_init_pkg::*;
#(
    parameter int unsigned NUM_LUTS  = 2,
    parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEFAULT,
    parameter int unsigned DATA_W    = SFU_LUT_W,
    parameter int unsigned ADDR_W    = $clog2(LUT_DEPTH),
    parameter int unsigned RD_LAT    = 1,
    parameter bit          VERIFY_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       verify,
    input  logic [NUM_LUTS-1:0]        lut_sel,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W:0]            count,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic [NUM_LUTS-1:0]        lut_wr_en,
    output logic [ADDR_W-1:0]          lut_addr,
    output logic [DATA_W-1:0]          lut_wr_data,
    output logic                       lut_rd_en,
    input  logic [NUM_LUTS*DATA_W-1:0] lut_rd_data,
    output logic                       cfg_en,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [NUM_LUTS-1:0]        err_lane,
    output logic                       cfg_kick
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(LUT_DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    lut_init_state_e     state_q, state_d;
    logic                ver_q, ver_d;
    logic [NUM_LUTS-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     left_q, left_d;
    logic [ADDR_W:0]     ret_q, ret_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [DATA_W-1:0]   wchk_q, wchk_d;
    logic                err_q, err_d;
    logic [NUM_LUTS-1:0] err_lane_q, err_lane_d;

    logic [ADDR_W:0]     cnt_sat;
    logic                wr_fire;
    logic                rd_en;
    logic                ret_vld;
    logic                lane_clr;
    logic [NUM_LUTS-1:0] lane_mis;

    assign cnt_sat = (count > DEPTH_L) ? DEPTH_L : count;
    assign ret_vld = vld_q[RD_LAT-1];

    // WRITE keeps one trailing cycle with s_ready low once left_q hits zero,
    // which gives the N+2 start-to-done latency while count 0 takes one cycle.
    always_comb begin
        state_d    = state_q;
        ver_d      = ver_q;
        sel_d      = sel_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        left_d     = left_q;
        ret_d      = ret_q;
        wchk_d     = wchk_q;
        err_d      = err_q;
        err_lane_d = err_lane_q;
        s_ready    = 1'b0;
        wr_fire    = 1'b0;
        rd_en      = 1'b0;
        done       = 1'b0;
        cfg_kick   = 1'b0;
        lane_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ver_d      = verify & VERIFY_EN;
                    sel_d      = lut_sel;
                    base_d     = base_addr;
                    cnt_d      = cnt_sat;
                    addr_d     = base_addr;
                    left_d     = cnt_sat;
                    wchk_d     = '0;
                    err_d      = 1'b0;
                    err_lane_d = '0;
                    lane_clr   = 1'b1;
                    state_d    = (cnt_sat == '0) ? FINISH : WRITE;
                end
            end
            WRITE: begin
                if (left_q != '0) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        wr_fire = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        left_d  = left_q - CNT_ONE;
                        wchk_d  = wchk_q ^ s_data;
                    end
                end else if (ver_q) begin
                    addr_d  = base_q;
                    left_d  = cnt_q;
                    ret_d   = cnt_q;
                    state_d = RDBACK;
                end else begin
                    state_d = FINISH;
                end
            end
            RDBACK: begin
                if (left_q != '0) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - CNT_ONE;
                end
                if (ret_vld) begin
                    ret_d = ret_q - CNT_ONE;
                    if (ret_q == CNT_ONE) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done     = 1'b1;
                cfg_kick = 1'b1;
                if (ver_q) begin
                    err_lane_d = lane_mis & sel_q;
                    err_d      = |(lane_mis & sel_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_en;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ver_q      <= 1'b0;
            sel_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            left_q     <= '0;
            ret_q      <= '0;
            vld_q      <= '0;
            wchk_q     <= '0;
            err_q      <= 1'b0;
            err_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            ver_q      <= ver_d;
            sel_q      <= sel_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            ret_q      <= ret_d;
            vld_q      <= vld_d;
            wchk_q     <= wchk_d;
            err_q      <= err_d;
            err_lane_q <= err_lane_d;
        end
    end

    generate
        if (VERIFY_EN) begin : g_verify
            for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lane
                lut_chk_lane #(
                    .DATA_W(DATA_W)
                ) u_chk (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .clr     (lane_clr),
                    .en      (ret_vld & sel_q[i]),
                    .din     (lut_rd_data[i*DATA_W +: DATA_W]),
                    .exp_chk (wchk_q),
                    .mismatch(lane_mis[i])
                );
            end
        end else begin : g_no_verify
            assign lane_mis = '0;
        end
    endgenerate

    assign lut_wr_en   = wr_fire ? sel_q : '0;
    assign lut_wr_data = wr_fire ? s_data : '0;
    assign lut_addr    = addr_q;
    assign lut_rd_en   = rd_en;
    assign busy        = (state_q != IDLE);
    assign cfg_en      = busy;
    assign err         = err_q;
    assign err_lane    = err_lane_q;

endmodule

// File: tb/tb_lut_init_sequencer.sv
// Bench for lut_init_sequencer: bank memory model, directed table, reset and random loads.
`timescale 1ns/1ps
module tb_lut_init_sequencer;

    localparam int NL    = 2;
    localparam int DEPTH = 4096;
    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int RDL   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            verify = 1'b0;
    logic [NL-1:0]   lut_sel = '0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW:0]     count = '0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready;
    logic [NL-1:0]   lut_wr_en;
    logic [AW-1:0]   lut_addr;
    logic [DW-1:0]   lut_wr_data;
    logic            lut_rd_en;
    logic [NL*DW-1:0] lut_rd_data;
    logic            cfg_en, busy, done, err, cfg_kick;
    logic [NL-1:0]   err_lane;

    always #5 clk = ~clk;

    lut_init_sequencer #(
        .NUM_LUTS (NL),
        .LUT_DEPTH(DEPTH),
        .DATA_W   (DW),
        .RD_LAT   (RDL),
        .VERIFY_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .verify     (verify),
        .lut_sel    (lut_sel),
        .base_addr  (base_addr),
        .count      (count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .lut_wr_en  (lut_wr_en),
        .lut_addr   (lut_addr),
        .lut_wr_data(lut_wr_data),
        .lut_rd_en  (lut_rd_en),
        .lut_rd_data(lut_rd_data),
        .cfg_en     (cfg_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_lane   (err_lane),
        .cfg_kick   (cfg_kick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Bank model: writes land on the clock edge, reads return RDL cycles later.
    // corrupt_en models a stuck bit 3 in lane 1 at one address.
    logic [DW-1:0]    mem [NL][DEPTH];
    logic [NL*DW-1:0] rd_pipe [RDL];
    logic [NL*DW-1:0] rd_word;
    bit               corrupt_en = 1'b0;
    logic [AW-1:0]    corrupt_addr = '0;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NL; i++) rd_word[i*DW +: DW] = mem[i][lut_addr];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (lut_wr_en[i]) begin
                mem[i][lut_addr] <= (corrupt_en && i == 1 && lut_addr == corrupt_addr)
                                    ? (lut_wr_data ^ 16'h0008) : lut_wr_data;
            end
        end
        rd_pipe[0] <= lut_rd_en ? rd_word : '0;
        for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign lut_rd_data = rd_pipe[RDL-1];

    typedef struct {
        logic [NL-1:0] m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  sr_viol = 0;
    int  kick_viol = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (lut_wr_en != '0) wq.push_back('{lut_wr_en, lut_addr, lut_wr_data});
        if (done) done_cnt++;
        if (done !== cfg_kick) kick_viol++;
        if (s_ready && !busy) sr_viol++;
    end

    logic [DW-1:0] words [5200];

    typedef struct {
        logic [NL-1:0] sel;
        int            base;
        int            cnt;
        bit            ver;
        int            gap;      // 0 always valid, 1 alternating, 2 random
        bit            corrupt;
        int            lat;      // expected start-to-done cycles, -1 unchecked
        int            exp_el;   // expected err_lane, -1 unchecked
    } vec_t;

    task automatic run_op(input vec_t v, input string tag);
        int n, idx, d0, t0, dcyc, budget, bad, first_bad, exp_wr;
        bit got;
        logic [DW-1:0] wchk, rchk;
        logic [NL-1:0] el;
        logic [AW-1:0] a;

        n = (v.cnt > DEPTH) ? DEPTH : v.cnt;
        for (int k = 0; k < n + 8; k++) words[k] = DW'($urandom);
        wq.delete();
        d0           = done_cnt;
        corrupt_en   = v.corrupt;
        corrupt_addr = AW'((v.base + 5) % DEPTH);
        verify       = v.ver;
        lut_sel      = v.sel;
        base_addr    = AW'(v.base);
        count        = (AW+1)'(v.cnt);
        idx    = 0;
        got    = 1'b0;
        dcyc   = 0;
        t0     = cyc;
        budget = 4 * n + 60;

        for (int c = 0; c < budget && !got; c++) begin
            start = (c == 0);
            case (v.gap)
                0:       s_valid = 1'b1;
                1:       s_valid = (c % 2 == 1);
                default: s_valid = $urandom_range(0, 1) == 1;
            endcase
            s_data = words[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        s_valid = 1'b0;

        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (v.lat >= 0) check({tag, "_latency"}, 64'(dcyc - t0), 64'(v.lat));
        check({tag, "_accepted"}, 64'(idx), 64'(n));

        exp_wr = (v.sel != '0) ? n : 0;
        check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_wr));
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < wq.size() && k < exp_wr; k++) begin
            a = AW'((v.base + k) % DEPTH);
            if (wq[k].m !== v.sel || wq[k].a !== a || wq[k].d !== words[k]) begin
                if (first_bad < 0) first_bad = k;
                bad++;
            end
        end
        check({tag, "_write_entries_bad"}, 64'(bad), 64'd0);
        if (first_bad >= 0)
            $display("  first bad write %0d: mask=%0h addr=%0d data=%0h want addr=%0d data=%0h",
                     first_bad, wq[first_bad].m, wq[first_bad].a, wq[first_bad].d,
                     (v.base + first_bad) % DEPTH, words[first_bad]);

        wchk = '0;
        for (int k = 0; k < n; k++) wchk ^= words[k];
        el = '0;
        if (v.ver) begin
            for (int i = 0; i < NL; i++) begin
                if (v.sel[i]) begin
                    rchk = '0;
                    for (int k = 0; k < n; k++) rchk ^= mem[i][(v.base + k) % DEPTH];
                    el[i] = (rchk != wchk);
                end
            end
        end

        @(negedge clk);
        check({tag, "_err_lane"}, 64'(err_lane), 64'(el));
        check({tag, "_err"}, 64'(err), 64'(|el));
        if (v.exp_el >= 0) check({tag, "_err_lane_fixed"}, 64'(err_lane), 64'(v.exp_el));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        corrupt_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        vec_t rv;
        int idx, d0;

        tbl[0] = '{sel: 2'b01, base: 0,    cnt: 4096, ver: 0, gap: 0, corrupt: 0, lat: 4098, exp_el: -1};
        tbl[1] = '{sel: 2'b01, base: 4094, cnt: 4,    ver: 0, gap: 0, corrupt: 0, lat: 6,    exp_el: -1};
        tbl[2] = '{sel: 2'b10, base: 100,  cnt: 8,    ver: 0, gap: 1, corrupt: 0, lat: -1,   exp_el: -1};
        tbl[3] = '{sel: 2'b11, base: 0,    cnt: 16,   ver: 1, gap: 0, corrupt: 1, lat: -1,   exp_el: 2};
        tbl[4] = '{sel: 2'b11, base: 7,    cnt: 0,    ver: 0, gap: 0, corrupt: 0, lat: 1,    exp_el: -1};
        tbl[5] = '{sel: 2'b10, base: 0,    cnt: 5000, ver: 0, gap: 0, corrupt: 0, lat: 4098, exp_el: -1};
        tbl[6] = '{sel: 2'b11, base: 4090, cnt: 20,   ver: 1, gap: 2, corrupt: 0, lat: -1,   exp_el: 0};
        tbl[7] = '{sel: 2'b00, base: 33,   cnt: 5,    ver: 0, gap: 0, corrupt: 0, lat: 7,    exp_el: -1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({s_ready, lut_wr_en, lut_addr, lut_wr_data, lut_rd_en, cfg_en, busy,
                   done, err, err_lane, cfg_kick}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 8; t++) run_op(tbl[t], $sformatf("vec%0d", t));

        // Reset while writing entry 100 of a 200-entry load.
        for (int k = 0; k < 210; k++) words[k] = DW'($urandom);
        d0        = done_cnt;
        verify    = 1'b0;
        lut_sel   = 2'b01;
        base_addr = '0;
        count     = 13'd200;
        idx       = 0;
        for (int c = 0; c < 400 && idx < 100; c++) begin
            start   = (c == 0);
            s_valid = 1'b1;
            s_data  = words[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        s_data = words[idx];
        check("rst_reached_entry100", 64'(idx), 64'd100);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_midload_outputs",
              64'({s_ready, lut_wr_en, lut_addr, lut_wr_data, lut_rd_en, cfg_en, busy,
                   done, err, err_lane, cfg_kick}), 64'd0);
        repeat (3) @(posedge clk);
        s_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        rv = '{sel: 2'b01, base: 0, cnt: 3, ver: 0, gap: 0, corrupt: 0, lat: 5, exp_el: -1};
        run_op(rv, "post_reset");

        for (int r = 0; r < 20; r++) begin
            rv.sel     = NL'($urandom_range(0, 3));
            rv.base    = $urandom_range(0, DEPTH - 1);
            rv.cnt     = $urandom_range(0, 40);
            rv.ver     = $urandom_range(0, 1) == 1;
            rv.gap     = 2;
            rv.corrupt = ($urandom_range(0, 3) == 0);
            rv.lat     = -1;
            rv.exp_el  = -1;
            run_op(rv, $sformatf("rand%0d", r));
        end

        check("s_ready_outside_write", 64'(sr_viol), 64'd0);
        check("kick_vs_done", 64'(kick_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lut_init_sequencer.md
Name: lut_init_sequencer

Overview:
Synthesizable multi-bank LUT loader for the SFU activation tables. It replaces bench-side forcing of params_write_lut, params_write_lut_addr and params_write_lut_data. The block accepts a valid/ready word stream, for example from the MFUNC DMA, and broadcasts each word into one or more LUT banks. It can optionally read the banks back and checksum-verify them, then emits a one-cycle config-kick pulse. It sits in CFG_TOP between the DMA read stream and the MFUNC_SFU LUT write/read ports.

Parameters:
NUM_LUTS, 2, number of LUT banks (lanes) driven
LUT_DEPTH, 4096, entries per bank; a power of two is required
DATA_W, 16, bits per LUT entry
ADDR_W, $clog2(LUT_DEPTH), address width (derived, do not override)
RD_LAT, 1, LUT read latency in cycles, range 1..4
VERIFY_EN, 1, 1 builds the readback checksum path; 0 removes it and ignores verify

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
verify  in  1  sampled with start; 1 runs the readback pass
lut_sel  in  NUM_LUTS  bank mask, sampled with start
base_addr  in  ADDR_W  first entry address
count  in  ADDR_W+1  number of entries; values above LUT_DEPTH saturate to LUT_DEPTH
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  stream word accepted when s_valid&&s_ready
lut_wr_en  out  NUM_LUTS  per-bank write strobe
lut_addr  out  ADDR_W  shared write/read address
lut_wr_data  out  DATA_W  shared write data
lut_rd_en  out  1  readback strobe to all selected banks
lut_rd_data  in  NUM_LUTS*DATA_W  per-bank read data, lane i at [i*DATA_W +: DATA_W]
cfg_en  out  1  high while busy; holds the DMA config path (replaces params_dma_cfg_en)
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse at completion
err  out  1  sticky verify failure; cleared on the next accepted start
err_lane  out  NUM_LUTS  lanes whose checksum mismatched
cfg_kick  out  1  one-cycle pulse, driven in the same cycle as done

Behaviour:
- Reset: every output is 0; FSM returns to IDLE; all counters and checksums clear. Reset asserted mid-load abandons the load with no done and no kick; partial bank contents are left as-is.
- States and transitions:
  - IDLE: on start, latch verify, lut_sel, base_addr and the saturated count. A lut_sel of 0 counts as a valid no-write load. Go to WRITE, or to FINISH if count is 0.
  - WRITE: s_ready=1. Each accepted word drives lut_wr_en=lut_sel, lut_addr=addr, lut_wr_data=s_data in the same cycle (combinational from the handshake); no write occurs when s_valid is 0.
    - addr increments modulo LUT_DEPTH, wrapping from 4095 to 0.
    - wchk ^= s_data on each accepted word.
    - After the last word go to RDBACK if (verify && VERIFY_EN), otherwise FINISH.
  - RDBACK: lut_rd_en=1 for count consecutive cycles from base_addr with the same wrap rule; lut_wr_en=0.
    - Data returns RD_LAT cycles later via a valid shift register.
    - For each lane i in lut_sel, rchk[i] ^= lane data. Enter FINISH after the last return.
  - FINISH: one cycle. done=1 and cfg_kick=1.
    - If verified, err_lane[i]=lut_sel[i]&&(rchk[i]!=wchk); err=|err_lane.
    - Next state is IDLE.
- Throughput is one entry per cycle with no bubbles when s_valid is held high. Latency for count N with no verify: start→done = N+2 cycles.
- s_ready is 0 outside WRITE and deasserts in the cycle after the last word is accepted.
- start while busy is ignored.
- Words beyond count are never accepted.

Decomposition:
- lut_init_pkg:
  - state enum lut_init_state_e {IDLE, WRITE, RDBACK, FINISH}
  - LUT_DEPTH_DEFAULT=4096
  - SFU_LUT_W=16
- Sub-module lut_chk_lane: one instance per lane, generated only when VERIFY_EN=1. It holds the per-lane XOR accumulator with clear/enable and a compare output.

Test Plan:
- Full load, lut_sel=2'b01, base 0, count 4096, s_valid held high → 4096 writes to bank 0 only, done 4098 cycles after start, cfg_kick coincident with done, err=0.
- Wrap: base_addr=4094, count 4, words A,B,C,D → addresses 4094,4095,0,1 with those data.
- Backpressure/gaps: s_valid toggled 1010… for count 8 → exactly 8 writes, no write on idle cycles, addresses contiguous.
- Verify with bank model, lut_sel=2'b11, count 16, lane 1 bit 3 of entry 5 corrupted → err=1, err_lane=2'b10, done still pulses once.
- count=0 → no s_ready, no lut_wr_en, done/cfg_kick 1 cycle after start; count=5000 → exactly 4096 writes.
- rst_n asserted during WRITE at entry 100 → outputs 0 immediately; no done; a following start with count 3 completes normally.
